regfile_writeback_queue: RTL and testbench

Buffers register-file writeback requests and serializes them onto the register file's single write port (dst_reg, dst_data, write_reg). It sits between the execute/memory writeback sources and the 16x16 register file. It also reports, for the two decode-side source addresses, whether a write to that register is still pending, so decode can stall. Optionally it forwards the pending data instead of stalling.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/wbq_fifo.sv | 72 +++++++
 rtl/regfile_writeback_queue.sv | 132 +++++++++++++
 tb/tb_regfile_writeback_queue.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and writeback entry type for regfile_writeback_queue
package regfile_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int REG_DATA_W = 16;
  localparam int NUM_REGS   = 16;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_fifo.sv
// rtl/wbq_fifo.sv - writeback entry FIFO exporting per-slot valid bits for pending-write matching
module wbq_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  wb_entry_t             push_entry,
  input  logic                  pop,
  output wb_entry_t             head,
  output wb_entry_t [DEPTH-1:0] entries,
  output logic [DEPTH-1:0]      valid,
  output logic [PTR_W-1:0]      rd_ptr,
  output logic [CNT_W-1:0]      count
);

  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Caller guarantees no push when full and no pop when empty.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + 1'b1;
    end
    if (push) begin
      mem_d[wr_ptr_q]   = push_entry;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '0;
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head    = mem_q[rd_ptr_q];
  assign entries = mem_q;
  assign valid   = valid_q;
  assign rd_ptr  = rd_ptr_q;
  assign count   = count_q;

endmodule

// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - writeback FIFO + output stage serializing onto the regfile write port
// Optional pending-data forwarding: REGFILE_WBQ_FORWARD_EN
module regfile_writeback_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wb_valid,
  output logic                         wb_ready,
  input  logic [REG_ADDR_W-1:0]        wb_reg,
  input  logic [REG_DATA_W-1:0]        wb_data,
  input  logic                         wb_hold,
  output logic [REG_ADDR_W-1:0]        dst_reg,
  output logic [REG_DATA_W-1:0]        dst_data,
  output logic                         write_reg,
  input  logic [REG_ADDR_W-1:0]        src_reg1,
  input  logic [REG_ADDR_W-1:0]        src_reg2,
  output logic                         busy1,
  output logic                         busy2,
  output logic                         fwd_hit1,
  output logic                         fwd_hit2,
  output logic [REG_DATA_W-1:0]        fwd_data1,
  output logic [REG_DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t             push_entry;
  wb_entry_t             fifo_head;
  wb_entry_t [DEPTH-1:0] fifo_entries;
  logic [DEPTH-1:0]      fifo_valid;
  logic [PTR_W-1:0]      fifo_rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;

  wb_entry_t out_entry_q, out_entry_d;
  logic      out_valid_q, out_valid_d;

  assign push_entry.addr = wb_reg;
  assign push_entry.data = wb_data;
  assign fifo_empty      = (fifo_count == '0);
  assign wb_ready        = rst && (fifo_count < CNT_W'(DEPTH));
  assign push            = wb_valid && wb_ready;
  assign pop             = !fifo_empty && !wb_hold;

  wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (fifo_head),
    .entries    (fifo_entries),
    .valid      (fifo_valid),
    .rd_ptr     (fifo_rd_ptr),
    .count      (fifo_count)
  );

  // Under hold the output stage freezes; otherwise it tracks the FIFO head.
  always_comb begin
    out_valid_d = out_valid_q;
    out_entry_d = out_entry_q;
    if (!wb_hold) begin
      out_valid_d = !fifo_empty;
      if (!fifo_empty) begin
        out_entry_d = fifo_head;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_entry_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_entry_q <= out_entry_d;
    end
  end

  assign write_reg = out_valid_q && !wb_hold;
  assign dst_reg   = out_entry_q.addr;
  assign dst_data  = out_entry_q.data;
  assign count     = fifo_count;

  always_comb begin
    busy1 = out_valid_q && (out_entry_q.addr == src_reg1);
    busy2 = out_valid_q && (out_entry_q.addr == src_reg2);
    for (int i = 0; i < DEPTH; i++) begin
      busy1 = busy1 | (fifo_valid[i] && (fifo_entries[i].addr == src_reg1));
      busy2 = busy2 | (fifo_valid[i] && (fifo_entries[i].addr == src_reg2));
    end
  end

`ifdef REGFILE_WBQ_FORWARD_EN
  logic [PTR_W-1:0] slot;

  // Walk oldest to youngest so the tail-most match overrides older ones.
  always_comb begin
    slot      = '0;
    fwd_data1 = (out_valid_q && (out_entry_q.addr == src_reg1)) ? out_entry_q.data : '0;
    fwd_data2 = (out_valid_q && (out_entry_q.addr == src_reg2)) ? out_entry_q.data : '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = fifo_rd_ptr + PTR_W'(k);
      if (fifo_valid[slot] && (fifo_entries[slot].addr == src_reg1)) begin
        fwd_data1 = fifo_entries[slot].data;
      end
      if (fifo_valid[slot] && (fifo_entries[slot].addr == src_reg2)) begin
        fwd_data2 = fifo_entries[slot].data;
      end
    end
  end

  assign fwd_hit1 = busy1;
  assign fwd_hit2 = busy2;
`else
  logic unused_fwd_inputs;

  assign unused_fwd_inputs = ^{fifo_rd_ptr, fifo_entries};
  assign fwd_hit1  = 1'b0;
  assign fwd_hit2  = 1'b0;
  assign fwd_data1 = '0;
  assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - directed bench with a queue-level reference model
module tb_regfile_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0;
  logic        wb_hold = 1'b0;
  logic [3:0]  wb_reg = '0;
  logic [15:0] wb_data = '0;
  logic [3:0]  src_reg1 = '0;
  logic [3:0]  src_reg2 = '0;
  logic        wb_ready;
  logic [3:0]  dst_reg;
  logic [15:0] dst_data;
  logic        write_reg;
  logic        busy1, busy2, fwd_hit1, fwd_hit2;
  logic [15:0] fwd_data1, fwd_data2;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  int base;

  logic [19:0] mq[$];
  logic        m_ov = 1'b0;
  logic [19:0] m_out = '0;
  logic        m_acc;
  logic        m_wr;
  logic [19:0] wlog[$];

  always #5 clk = ~clk;

  regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_reg    (wb_reg),
    .wb_data   (wb_data),
    .wb_hold   (wb_hold),
    .dst_reg   (dst_reg),
    .dst_data  (dst_data),
    .write_reg (write_reg),
    .src_reg1  (src_reg1),
    .src_reg2  (src_reg2),
    .busy1     (busy1),
    .busy2     (busy2),
    .fwd_hit1  (fwd_hit1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data1 (fwd_data1),
    .fwd_data2 (fwd_data2),
    .count     (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic m_busy(input logic [3:0] src);
    logic b;
    b = m_ov && (m_out[19:16] == src);
    foreach (mq[i]) if (mq[i][19:16] == src) b = 1'b1;
    return b;
  endfunction

  function automatic logic [15:0] m_fwd(input logic [3:0] src);
    logic [15:0] d;
    d = '0;
    if (m_ov && (m_out[19:16] == src)) d = m_out[15:0];
    foreach (mq[i]) if (mq[i][19:16] == src) d = mq[i][15:0];
    return d;
  endfunction

  // Reference model: a plain queue of pending writes plus one issuing slot.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_ov = 1'b0;
    end else begin
      m_acc = wb_valid && (mq.size() < DEPTH);
      if (!wb_hold) begin
        if (mq.size() > 0) begin
          m_ov  = 1'b1;
          m_out = mq.pop_front();
        end else begin
          m_ov = 1'b0;
        end
      end
      if (m_acc) mq.push_back({wb_reg, wb_data});
    end
  end

  always @(negedge clk) begin
    if (write_reg) wlog.push_back({dst_reg, dst_data});
    m_wr = rst && m_ov && !wb_hold;
    chk("write_reg", write_reg, m_wr);
    if (m_wr) chk("dst", {dst_reg, dst_data}, m_out);
    chk("count", count, mq.size());
    chk("wb_ready", wb_ready, rst && (mq.size() < DEPTH));
    chk("busy1", busy1, m_busy(src_reg1));
    chk("busy2", busy2, m_busy(src_reg2));
`ifdef REGFILE_WBQ_FORWARD_EN
    chk("fwd_hit1", fwd_hit1, m_busy(src_reg1));
    chk("fwd_hit2", fwd_hit2, m_busy(src_reg2));
    chk("fwd_data1", fwd_data1, m_fwd(src_reg1));
    chk("fwd_data2", fwd_data2, m_fwd(src_reg2));
`else
    chk("fwd_hit1_off", fwd_hit1, 0);
    chk("fwd_data1_off", fwd_data1, 0);
    chk("fwd_hit2_off", fwd_hit2, 0);
    chk("fwd_data2_off", fwd_data2, 0);
`endif
  end

  task automatic push_one(input logic [3:0] r, input logic [15:0] d);
    wb_valid = 1'b1;
    wb_reg   = r;
    wb_data  = d;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    chk("rst_write_reg", write_reg, 0);
    chk("rst_dst_reg", dst_reg, 0);
    chk("rst_dst_data", dst_data, 0);
    chk("rst_count", count, 0);
    chk("rst_wb_ready", wb_ready, 0);
    rst = 1'b1;
    #1;
    chk("ready_after_rst", wb_ready, 1);
    tick();

    // Single write of r5
    src_reg1 = 4'd5;
    src_reg2 = 4'd6;
    base = wlog.size();
    push_one(4'd5, 16'hBEEF);
    chk("sw_busy_accept", busy1, 1);
    chk("sw_wr_accept", write_reg, 0);
    chk("sw_count_accept", count, 1);
    tick();
    chk("sw_write", write_reg, 1);
    chk("sw_dst_reg", dst_reg, 5);
    chk("sw_dst_data", dst_data, 16'hBEEF);
    chk("sw_busy_write", busy1, 1);
    chk("sw_busy2", busy2, 0);
    tick();
    chk("sw_busy_done", busy1, 0);
    chk("sw_wr_done", write_reg, 0);
    chk("sw_log_n", wlog.size() - base, 1);

    // Hold while the output stage is valid gates write_reg but keeps dst
    base = wlog.size();
    push_one(4'd10, 16'h0A0A);
    wb_hold = 1'b1;
    tick();
    chk("hold_no_pop", count, 1);
    wb_hold = 1'b0;
    tick();
    chk("hold_out_wr", write_reg, 1);
    wb_hold = 1'b1;
    #1;
    chk("hold_gate_wr", write_reg, 0);
    chk("hold_keep_dst", dst_reg, 10);
    tick();
    wb_hold = 1'b0;
    #1;
    chk("hold_release_wr", write_reg, 1);
    tick();
    chk("hold_log_n", wlog.size() - base, 1);
    chk("hold_log_0", wlog[base], 20'hA0A0A);

    // Back-to-back r1..r4
    base = wlog.size();
    for (int i = 1; i <= 4; i++) begin
      wb_valid = 1'b1;
      wb_reg   = 4'(i);
      wb_data  = 16'h1000 + 16'(i);
      tick();
      chk("b2b_count_le1", count <= 3'd1, 1);
    end
    wb_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("b2b_log_n", wlog.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      logic [19:0] expw;
      expw = {4'(i + 1), 16'h1000 + 16'(i + 1)};
      if (wlog.size() > base + i) chk("b2b_order", wlog[base + i], expw);
    end

    // Fill under hold; 5th request must be refused
    base = wlog.size();
    src_reg2 = 4'd4;
    wb_hold  = 1'b1;
    wb_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wb_reg  = 4'(i);
      wb_data = 16'hA000 + 16'(i);
      tick();
    end
    wb_valid = 1'b0;
    chk("full_count", count, 4);
    chk("full_ready", wb_ready, 0);
    chk("full_5th_absent", busy2, 0);
    wb_hold = 1'b0;
    tick();
    chk("drain_count", count, 3);
    chk("drain_ready", wb_ready, 1);
    chk("drain_first", {dst_reg, dst_data}, 20'h0A000);
    for (int i = 0; i < 4; i++) tick();
    chk("full_log_n", wlog.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      logic [19:0] expw;
      expw = {4'(i), 16'hA000 + 16'(i)};
      if (wlog.size() > base + i) chk("full_order", wlog[base + i], expw);
    end

    // Duplicate destination r3
    base = wlog.size();
    src_reg1 = 4'd3;
    wb_hold  = 1'b1;
    push_one(4'd3, 16'h1111);
    push_one(4'd3, 16'h2222);
    chk("dup_busy", busy1, 1);
`ifdef REGFILE_WBQ_FORWARD_EN
    chk("dup_fwd_hit", fwd_hit1, 1);
    chk("dup_fwd_data", fwd_data1, 16'h2222);
`endif
    wb_hold = 1'b0;
    tick();
`ifdef REGFILE_WBQ_FORWARD_EN
    chk("dup_fwd_fifo_over_out", fwd_data1, 16'h2222);
`endif
    tick();
    tick();
    chk("dup_busy_done", busy1, 0);
    chk("dup_log_n", wlog.size() - base, 2);
    if (wlog.size() >= base + 2) begin
      chk("dup_first", wlog[base], 20'h31111);
      chk("dup_second", wlog[base + 1], 20'h32222);
    end

    // Asynchronous reset mid-drain
    src_reg1 = 4'd8;
    wb_hold  = 1'b1;
    push_one(4'd7, 16'h7777);
    push_one(4'd8, 16'h8888);
    push_one(4'd9, 16'h9999);
    wb_hold = 1'b0;
    tick();
    chk("mid_wr_before", write_reg, 1);
    chk("mid_count_before", count, 2);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_wr", write_reg, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_ready", wb_ready, 0);
    chk("mid_rst_dst", {dst_reg, dst_data}, 0);
    base = wlog.size();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("mid_no_stale", wlog.size() - base, 0);
    chk("mid_count_after", count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
